// File: rtl/note_event_encoder.sv
// rtl/note_event_encoder.sv - per-voice note state to serial MIDI note-on/note-off byte stream
//
// Purpose:
//   Watches COUNT voice slots (enable, note, velocity). It keeps a snapshot of
//   the state it last reported. Slots whose state differs from the snapshot
//   are served round-robin. Each serviced change becomes a MIDI channel-voice
//   message on a valid/ready byte interface. The snapshot is committed only
//   after the last byte of a message is accepted.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   channel        MIDI channel, OR'd into the status nibble at capture
//   notes_in_en    per-slot voice active
//   notes_in       per-slot note number, slot i at [i*7 +: 7]
//   velocities_in  per-slot velocity, slot i at [i*7 +: 7]
//   byte_out       MIDI byte (registered)
//   byte_valid     byte_out holds a valid byte
//   byte_ready     downstream accepts byte_out this cycle
//   busy           message in flight
module note_event_encoder #(
  parameter int         COUNT            = 4,
  parameter bit         RUNNING_STATUS   = 1'b0,
  parameter logic [6:0] RELEASE_VELOCITY = 7'h40
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         channel,
  input  logic [COUNT-1:0]   notes_in_en,
  input  logic [COUNT*7-1:0] notes_in,
  input  logic [COUNT*7-1:0] velocities_in,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               busy
);

  localparam int PTR_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} state_t;

  state_t             state;
  logic [COUNT-1:0]   snap_en;
  logic [6:0]         snap_note [COUNT];
  logic [PTR_W-1:0]   rr_ptr;
  logic [7:0]         last_status;

  // Message captured at selection; later input changes cannot alter it.
  logic [7:0]         cap_status;
  logic [6:0]         cap_d1;
  logic [6:0]         cap_d2;
  logic               cap_off;
  logic [PTR_W-1:0]   cap_slot;

  logic [6:0]         note_arr [COUNT];
  logic [6:0]         vel_arr  [COUNT];
  logic [COUNT-1:0]   off_req;
  logic [COUNT-1:0]   on_req;
  logic [COUNT-1:0]   any_req;

  // Change detection against the last reported state. Velocity-only changes
  // on an active slot are deliberately ignored.
  for (genvar i = 0; i < COUNT; i++) begin : g_slot
    assign note_arr[i] = notes_in[i*7 +: 7];
    assign vel_arr[i]  = velocities_in[i*7 +: 7];
    assign off_req[i]  = snap_en[i] & (~notes_in_en[i] | (note_arr[i] != snap_note[i]));
    assign on_req[i]   = ~snap_en[i] & notes_in_en[i];
    assign any_req[i]  = off_req[i] | on_req[i];
  end

  // Round-robin search: first requesting slot at or after rr_ptr, wrapping.
  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;

  always_comb begin : arb
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < COUNT; k++) begin
      idx = (int'(rr_ptr) + k) % COUNT;
      if (!sel_found && any_req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

  // Fields of the message that would be captured this cycle. An off takes
  // priority. A pending on for the same slot is picked up in a later
  // selection, once the snapshot shows the slot as off.
  logic             sel_off;
  logic [6:0]       sel_note;
  logic [6:0]       sel_d2;
  logic [7:0]       sel_status;
  logic             skip_status;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    sel_off     = off_req[sel_idx];
    sel_note    = sel_off ? snap_note[sel_idx] : note_arr[sel_idx];
    if (sel_off) begin
      sel_d2 = RELEASE_VELOCITY;
    end else begin
      // A note-on with velocity 0 would read as a note-off, so clamp to 1.
      sel_d2 = (vel_arr[sel_idx] == 7'd0) ? 7'd1 : vel_arr[sel_idx];
    end
    sel_status  = {(sel_off ? 4'h8 : 4'h9), channel};
    // last_status resets to 8'h00, which never matches a real status byte.
    skip_status = RUNNING_STATUS && (sel_status == last_status);
    ptr_next    = (sel_idx == PTR_W'(COUNT - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      byte_out    <= 8'h00;
      byte_valid  <= 1'b0;
      busy        <= 1'b0;
      snap_en     <= '0;
      for (int i = 0; i < COUNT; i++) snap_note[i] <= 7'd0;
      rr_ptr      <= '0;
      last_status <= 8'h00;
      cap_status  <= 8'h00;
      cap_d1      <= 7'd0;
      cap_d2      <= 7'd0;
      cap_off     <= 1'b0;
      cap_slot    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            cap_status <= sel_status;
            cap_d1     <= sel_note;
            cap_d2     <= sel_d2;
            cap_off    <= sel_off;
            cap_slot   <= sel_idx;
            rr_ptr     <= ptr_next;
            byte_valid <= 1'b1;
            busy       <= 1'b1;
            if (skip_status) begin
              state    <= DATA1;
              byte_out <= {1'b0, sel_note};
            end else begin
              state    <= STATUS;
              byte_out <= sel_status;
            end
          end
        end
        STATUS: begin
          if (byte_ready) begin
            last_status <= cap_status;
            byte_out    <= {1'b0, cap_d1};
            state       <= DATA1;
          end
        end
        DATA1: begin
          if (byte_ready) begin
            byte_out <= {1'b0, cap_d2};
            state    <= DATA2;
          end
        end
        DATA2: begin
          if (byte_ready) begin
            // The snapshot changes only once the whole message has gone out.
            if (cap_off) begin
              snap_en[cap_slot] <= 1'b0;
            end else begin
              snap_en[cap_slot]   <= 1'b1;
              snap_note[cap_slot] <= cap_d1;
            end
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_event_encoder.sv
// tb/tb_note_event_encoder.sv - self-checking bench for note_event_encoder
module tb_note_event_encoder;

  localparam int COUNT = 4;

  logic               clk;
  logic               reset_n;
  logic [3:0]         channel;
  logic [COUNT-1:0]   en_a, en_b;
  logic [COUNT*7-1:0] notes_a, notes_b, vel_a, vel_b;
  logic [7:0]         byte_a, byte_b;
  logic               valid_a, valid_b, ready_a, ready_b, busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  note_event_encoder #(.COUNT(COUNT), .RUNNING_STATUS(1'b0), .RELEASE_VELOCITY(7'h40)) dut (
    .clk(clk), .reset_n(reset_n), .channel(channel),
    .notes_in_en(en_a), .notes_in(notes_a), .velocities_in(vel_a),
    .byte_out(byte_a), .byte_valid(valid_a), .byte_ready(ready_a), .busy(busy_a)
  );

  note_event_encoder #(.COUNT(COUNT), .RUNNING_STATUS(1'b1), .RELEASE_VELOCITY(7'h40)) dut_rs (
    .clk(clk), .reset_n(reset_n), .channel(channel),
    .notes_in_en(en_b), .notes_in(notes_b), .velocities_in(vel_b),
    .byte_out(byte_b), .byte_valid(valid_b), .byte_ready(ready_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] o_valid(input bit which);
    return which ? 32'(valid_b) : 32'(valid_a);
  endfunction
  function automatic logic [31:0] o_byte(input bit which);
    return which ? 32'(byte_b) : 32'(byte_a);
  endfunction
  function automatic logic [31:0] o_busy(input bit which);
    return which ? 32'(busy_b) : 32'(busy_a);
  endfunction

  // Random-phase velocity is a fixed function of the note, so a note-on's
  // data-2 byte can be predicted from its data-1 byte alone.
  function automatic logic [6:0] vf(input int n);
    return 7'((n * 5) & 127);
  endfunction
  function automatic logic [6:0] clampv(input logic [6:0] v);
    return (v == 7'd0) ? 7'd1 : v;
  endfunction

  task automatic set_slot(input bit which, input int s, input bit en,
                          input logic [6:0] note, input logic [6:0] vel);
    if (!which) begin
      en_a[s] = en; notes_a[s*7 +: 7] = note; vel_a[s*7 +: 7] = vel;
    end else begin
      en_b[s] = en; notes_b[s*7 +: 7] = note; vel_b[s*7 +: 7] = vel;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at the negedge of the idle cycle in which a change is visible.
  // Expects n bytes in the following n cycles, then an idle cycle.
  task automatic send_chk(input string tag, input bit which, input int n,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] e [3];
    e[0] = b0; e[1] = b1; e[2] = b2;
    chk({tag, "_pre_valid"}, o_valid(which), 32'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s_valid%0d", tag, k), o_valid(which), 32'd1);
      chk($sformatf("%s_byte%0d", tag, k), o_byte(which), 32'(e[k]));
      chk($sformatf("%s_busy%0d", tag, k), o_busy(which), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_post_valid"}, o_valid(which), 32'd0);
    chk({tag, "_post_busy"}, o_busy(which), 32'd0);
  endtask

  // Byte monitor for the random phase: accepted bytes and hold-while-stalled.
  logic       mon_en = 1'b0;
  logic [7:0] acc_q [$];
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (prev_stall && (!valid_a || byte_a !== prev_byte)) stall_viol++;
      if (valid_a && ready_a) acc_q.push_back(byte_a);
      prev_stall = valid_a && !ready_a;
      prev_byte  = byte_a;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int sounding [128];
    int expc [128];
    int idle_run;
    logic [7:0] m0, m1, m2;

    reset_n = 1'b0; channel = 4'd2;
    en_a = '0; notes_a = '0; vel_a = '0; en_b = '0; notes_b = '0; vel_b = '0;
    ready_a = 1'b1; ready_b = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_byte_a",  32'(byte_a),  32'h00);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_busy_a",  32'(busy_a),  32'd0);
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic note-on then note-off.
    set_slot(0, 0, 1'b1, 7'd60, 7'd100);
    send_chk("on60", 0, 3, 8'h92, 8'h3C, 8'h64);
    set_slot(0, 0, 1'b0, 7'd60, 7'd100);
    send_chk("off60", 0, 3, 8'h82, 8'h3C, 8'h40);

    // Running status: second note-on omits the status byte.
    set_slot(1, 0, 1'b1, 7'd60, 7'd100);
    send_chk("rs_first", 1, 3, 8'h92, 8'h3C, 8'h64);
    set_slot(1, 1, 1'b1, 7'd64, 7'd100);
    send_chk("rs_second", 1, 2, 8'h40, 8'h64, 8'h00);

    // Simultaneous changes served round-robin from pointer 0.
    en_b = '0;
    do_reset();
    set_slot(0, 1, 1'b1, 7'd50, 7'd10);
    set_slot(0, 3, 1'b1, 7'd70, 7'd20);
    send_chk("rr_s1", 0, 3, 8'h92, 8'h32, 8'h0A);
    send_chk("rr_s3", 0, 3, 8'h92, 8'h46, 8'h14);
    set_slot(0, 0, 1'b1, 7'd40, 7'd30);
    set_slot(0, 1, 1'b0, 7'd50, 7'd10);
    send_chk("rr_s0", 0, 3, 8'h92, 8'h28, 8'h1E);
    send_chk("rr_s1off", 0, 3, 8'h82, 8'h32, 8'h40);

    // Stall in DATA1 with an input change during the stall.
    set_slot(0, 2, 1'b1, 7'd60, 7'h55);
    chk("stall_pre", 32'(valid_a), 32'd0);
    @(negedge clk);
    chk("stall_status", 32'(byte_a), 32'h92);
    @(negedge clk);
    chk("stall_d1", 32'(byte_a), 32'h3C);
    ready_a = 1'b0;
    set_slot(0, 2, 1'b1, 7'd65, 7'h55);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_valid%0d", k), 32'(valid_a), 32'd1);
      chk($sformatf("stall_hold_byte%0d", k), 32'(byte_a), 32'h3C);
    end
    ready_a = 1'b1;
    @(negedge clk);
    chk("stall_d2", 32'(byte_a), 32'h55);
    @(negedge clk);
    send_chk("stall_off", 0, 3, 8'h82, 8'h3C, 8'h40);
    send_chk("stall_on", 0, 3, 8'h92, 8'h41, 8'h55);

    // Note change on an enabled slot, and zero-velocity clamp.
    set_slot(0, 2, 1'b1, 7'd60, 7'h55);
    send_chk("chg_off65", 0, 3, 8'h82, 8'h41, 8'h40);
    send_chk("chg_on60", 0, 3, 8'h92, 8'h3C, 8'h55);
    set_slot(0, 2, 1'b1, 7'd62, 7'd0);
    send_chk("chg_off60", 0, 3, 8'h82, 8'h3C, 8'h40);
    send_chk("chg_on62", 0, 3, 8'h92, 8'h3E, 8'h01);

    // Reset during DATA1 abandons the message; the on is re-sent in full.
    en_a = '0;
    do_reset();
    set_slot(0, 0, 1'b1, 7'd60, 7'd100);
    @(negedge clk);
    chk("mid_status", 32'(byte_a), 32'h92);
    @(negedge clk);
    chk("mid_d1", 32'(byte_a), 32'h3C);
    reset_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(valid_a), 32'd0);
    chk("mid_async_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send_chk("mid_resend", 0, 3, 8'h92, 8'h3C, 8'h64);

    // Randomized phase checked against a multiset-of-sounding-notes model.
    en_a = '0;
    channel = 4'd5;
    do_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int s, n;
        s = int'($urandom_range(0, COUNT - 1));
        n = int'($urandom_range(0, 15));
        set_slot(0, s, 1'($urandom_range(0, 1)), 7'(n), vf(n));
      end
      ready_a = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end
    ready_a = 1'b1;
    idle_run = 0;
    for (int c = 0; c < 400 && idle_run < 4; c++) begin
      @(negedge clk);
      idle_run = busy_a ? 0 : idle_run + 1;
    end
    chk("rand_quiesce", 32'(idle_run >= 4), 32'd1);
    @(negedge clk);
    mon_en = 1'b0;
    chk("rand_stall_hold", 32'(stall_viol), 32'd0);
    chk("rand_len_mod3", 32'(acc_q.size() % 3), 32'd0);

    for (int n = 0; n < 128; n++) begin sounding[n] = 0; expc[n] = 0; end
    for (int i = 0; i + 2 < acc_q.size(); i += 3) begin
      m0 = acc_q[i]; m1 = acc_q[i+1]; m2 = acc_q[i+2];
      chk("rand_status", 32'(m0 == 8'h85 || m0 == 8'h95), 32'd1);
      chk("rand_d1_msb", 32'(m1[7]), 32'd0);
      if (m0 == 8'h95) begin
        chk("rand_on_vel", 32'(m2), 32'(clampv(vf(int'(m1[6:0])))));
        sounding[m1[6:0]]++;
      end else begin
        chk("rand_off_vel", 32'(m2), 32'h40);
        chk("rand_off_sounding", 32'(sounding[m1[6:0]] > 0), 32'd1);
        if (sounding[m1[6:0]] > 0) sounding[m1[6:0]]--;
      end
    end
    for (int s = 0; s < COUNT; s++) if (en_a[s]) expc[notes_a[s*7 +: 7]]++;
    for (int n = 0; n < 16; n++)
      chk($sformatf("rand_final_note%0d", n), 32'(sounding[n]), 32'(expc[n]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
